// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared defaults and word/address types for the dram scratch memory
package dram_pkg;
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDR_WIDTH    = 4;
    localparam int DEF_DEPTH         = 1 << DEF_ADDR_WIDTH;
    localparam int DEF_RETENTION_CYC = 64;

    typedef logic [DEF_DATA_WIDTH-1:0] word_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/dram_retention.sv
// rtl/dram_retention.sv - per-word age counters flagging words lost to missed refresh (DRAM_RETENTION_EN)
module dram_retention
    import dram_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int RETENTION_CYC = DEF_RETENTION_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refresh,
    input  logic [DEPTH-1:0] wr_hit,
    output logic [DEPTH-1:0] expired
);
    localparam int AGE_W = $clog2(RETENTION_CYC) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RETENTION_CYC);

    logic [AGE_W-1:0] age [DEPTH];

    // Ages saturate so a lost word stays flagged until rewritten or refreshed.
    always_ff @(posedge clk) begin
        if (rst || refresh) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i])
                    age[i] <= '0;
                else if (age[i] != AGE_MAX)
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_comb begin
        expired = '0;
        for (int i = 0; i < DEPTH; i++) expired[i] = (age[i] == AGE_MAX);
    end
endmodule

// File: rtl/dram.sv
// rtl/dram.sv - true dual-port scratch DRAM model with refresh stall; DRAM_RETENTION_EN adds data decay
module dram
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int RETENTION_CYC = DEF_RETENTION_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic                  read_en_a,
    input  logic                  read_en_b,
    input  logic                  refresh_en,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      expired;
    logic                  a_dropped;

    assign a_dropped = we_b && (addr_b == addr_a);

`ifdef DRAM_RETENTION_EN
    logic [DEPTH-1:0] wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < DEPTH; i++)
            wr_hit[i] = !refresh_en &&
                        ((we_a && addr_a == ADDR_WIDTH'(i)) || (we_b && addr_b == ADDR_WIDTH'(i)));
    end

    dram_retention #(
        .DEPTH         (DEPTH),
        .RETENTION_CYC (RETENTION_CYC)
    ) u_retention (
        .clk     (clk),
        .rst     (rst),
        .refresh (refresh_en),
        .wr_hit  (wr_hit),
        .expired (expired)
    );
`else
    logic unused_retention;
    assign unused_retention = ^RETENTION_CYC;
    assign expired = '0;
`endif

    // Expiry wipes happen even in refresh cycles, so a refresh cannot resurrect a lost word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (expired[i]) mem[i] <= '0;
            if (!refresh_en) begin
                if (read_en_a) data_out_a <= expired[addr_a] ? '0 : mem[addr_a];
                if (read_en_b) data_out_b <= expired[addr_b] ? '0 : mem[addr_b];
                if (we_a && !a_dropped) mem[addr_a] <= data_in_a;
                if (we_b)               mem[addr_b] <= data_in_b;
            end
        end
    end
endmodule

// File: tb/tb_dram.sv
// tb/tb_dram.sv - directed vector table plus randomized model comparison for dram (DRAM_RETENTION_EN aware)
module tb_dram;
    import dram_pkg::*;

    localparam int RET = DEF_RETENTION_CYC;

    typedef struct {
        logic  rst, we_a, we_b, re_a, re_b, rf;
        addr_t aa, ab;
        word_t da, db;
        word_t ea, eb;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst, we_a, we_b, read_en_a, read_en_b, refresh_en;
    addr_t addr_a, addr_b;
    word_t data_in_a, data_in_b, data_out_a, data_out_b;

    int checks   = 0;
    int failures = 0;

    word_t m_mem [16];
    int    m_age [16];
    word_t m_out_a, m_out_b;

    vec_t tbl [15];

    dram dut (
        .clk        (clk),
        .rst        (rst),
        .we_a       (we_a),
        .we_b       (we_b),
        .read_en_a  (read_en_a),
        .read_en_b  (read_en_b),
        .refresh_en (refresh_en),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .data_in_a  (data_in_a),
        .data_in_b  (data_in_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic wa, input logic wb, input logic ra,
                                input logic rb, input logic f, input int aa, input int ab,
                                input word_t da, input word_t db, input word_t ea, input word_t eb);
        vec_t v;
        v.rst = r; v.we_a = wa; v.we_b = wb; v.re_a = ra; v.re_b = rb; v.rf = f;
        v.aa = addr_t'(aa); v.ab = addr_t'(ab); v.da = da; v.db = db; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
    task automatic apply(input vec_t v);
        rst = v.rst; we_a = v.we_a; we_b = v.we_b; read_en_a = v.re_a; read_en_b = v.re_b;
        refresh_en = v.rf; addr_a = v.aa; addr_b = v.ab; data_in_a = v.da; data_in_b = v.db;
        @(posedge clk);
        #1;
    endtask

    function automatic word_t m_val(input int i);
`ifdef DRAM_RETENTION_EN
        if (m_age[i] >= RET) return '0;
`endif
        return m_mem[i];
    endfunction

    // Reference behaviour: reads see the pre-edge contents, B's write lands after A's.
    task automatic model_step(input vec_t v);
        word_t ra, rb;
        if (v.rst) begin
            for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_age[i] = 0; end
            m_out_a = '0;
            m_out_b = '0;
        end else if (v.rf) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i] = m_val(i);
                m_age[i] = 0;
            end
        end else begin
            ra = m_val(int'(v.aa));
            rb = m_val(int'(v.ab));
            if (v.re_a) m_out_a = ra;
            if (v.re_b) m_out_b = rb;
            for (int i = 0; i < 16; i++) begin
                m_mem[i] = m_val(i);
                if (m_age[i] < RET) m_age[i]++;
            end
            if (v.we_a) begin m_mem[v.aa] = v.da; m_age[v.aa] = 0; end
            if (v.we_b) begin m_mem[v.ab] = v.db; m_age[v.ab] = 0; end
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; we_a = 1'b0; we_b = 1'b0; read_en_a = 1'b0; read_en_b = 1'b0;
        refresh_en = 1'b0; addr_a = '0; addr_b = '0; data_in_a = '0; data_in_b = '0;

        //             rst we_a we_b re_a re_b rf  aa ab  da       db       ea       eb
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 1, 1, 0, 0, 0,  0, 15, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 1, 1, 0,  0, 15, 16'h0000, 16'h0000, 16'hAAAA, 16'h5555);
        tbl[3]  = mk(0, 1, 1, 0, 0, 0,  5,  5, 16'h1111, 16'h2222, 16'hAAAA, 16'h5555);
        tbl[4]  = mk(0, 0, 0, 1, 1, 0,  5,  5, 16'h0000, 16'h0000, 16'h2222, 16'h2222);
        tbl[5]  = mk(0, 1, 0, 1, 0, 0,  3,  0, 16'hFACE, 16'h0000, 16'h0000, 16'h2222);
        tbl[6]  = mk(0, 0, 0, 1, 0, 0,  3,  0, 16'h0000, 16'h0000, 16'hFACE, 16'h2222);
        tbl[7]  = mk(0, 0, 0, 0, 1, 0,  0,  7, 16'h0000, 16'h0000, 16'hFACE, 16'h0000);
        tbl[8]  = mk(0, 0, 1, 1, 1, 1,  5,  9, 16'h0000, 16'hBEEF, 16'hFACE, 16'h0000);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0,  0,  9, 16'h0000, 16'h0000, 16'hFACE, 16'h0000);
        tbl[10] = mk(0, 1, 0, 0, 1, 0,  4,  4, 16'h1357, 16'h0000, 16'hFACE, 16'h0000);
        tbl[11] = mk(0, 0, 0, 0, 1, 0,  0,  4, 16'h0000, 16'h0000, 16'hFACE, 16'h1357);
        tbl[12] = mk(0, 0, 0, 1, 1, 1,  0,  5, 16'h0000, 16'h0000, 16'hFACE, 16'h1357);
        tbl[13] = mk(1, 1, 1, 1, 1, 0,  6,  7, 16'h9999, 16'h8888, 16'h0000, 16'h0000);
        tbl[14] = mk(0, 0, 0, 1, 1, 0,  0,  5, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
            check($sformatf("vec%0d_out_a", i), data_out_a, tbl[i].ea);
            check($sformatf("vec%0d_out_b", i), data_out_b, tbl[i].eb);
        end

        v = mk(1, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        apply(v);
        model_step(v);
        for (int n = 0; n < 600; n++) begin
            int span;
            span = ($urandom_range(0, 1) == 0) ? 3 : 15;
            v.rst  = ($urandom_range(0, 99) == 0);
            v.rf   = ($urandom_range(0, 7) == 0);
            v.we_a = $urandom_range(0, 1) == 1;
            v.we_b = $urandom_range(0, 1) == 1;
            v.re_a = $urandom_range(0, 1) == 1;
            v.re_b = $urandom_range(0, 1) == 1;
            v.aa   = addr_t'($urandom_range(0, span));
            v.ab   = addr_t'($urandom_range(0, span));
            v.da   = word_t'($urandom);
            v.db   = word_t'($urandom);
            apply(v);
            model_step(v);
            check($sformatf("rand%0d_out_a", n), data_out_a, m_out_a);
            check($sformatf("rand%0d_out_b", n), data_out_b, m_out_b);
        end

`ifdef DRAM_RETENTION_EN
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0));
        apply(mk(0, 1, 0, 0, 0, 0, 2, 0, 16'h1234, '0, '0, '0));
        for (int n = 0; n < RET; n++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0));
        apply(mk(0, 0, 0, 1, 0, 0, 2, 0, '0, '0, '0, '0));
        check("ret_expired", data_out_a, 16'h0000);

        apply(mk(0, 1, 0, 0, 0, 0, 2, 0, 16'h1234, '0, '0, '0));
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < RET - 2; n++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0));
            apply(mk(0, 0, 0, 0, 0, 1, 0, 0, '0, '0, '0, '0));
        end
        apply(mk(0, 0, 0, 1, 0, 0, 2, 0, '0, '0, '0, '0));
        check("ret_refreshed", data_out_a, 16'h1234);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
